// File: rtl/pd_rx_byte_buffer_pkg.sv
// Shared constants and mask helpers for the PHY-data receive byte buffer.
package pd_rx_byte_buffer_pkg;

    localparam int PD_BUS_BYTES = 64;
    localparam int PD_BUS_WIDTH = 512;

    typedef enum logic [2:0] {
        PD_GEN1 = 3'd1,
        PD_GEN2 = 3'd2,
        PD_GEN3 = 3'd3,
        PD_GEN4 = 3'd4,
        PD_GEN5 = 3'd5
    } pd_gen_e;

    function automatic logic [6:0] popcount64(input logic [63:0] mask);
        logic [6:0] cnt;
        cnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {6'd0, mask[i]};
        end
        return cnt;
    endfunction

    // A mask of the form 2^k-1 has no set bit above its first clear bit.
    function automatic logic is_contiguous_mask(input logic [63:0] mask);
        return ((mask & (mask + 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/pd_rx_byte_buffer_if.sv
// Write-beat and read-word handshake bundle between the lane controller, buffer and DLL.
interface pd_rx_byte_buffer_if;
    import pd_rx_byte_buffer_pkg::*;

    logic                      wr_en;
    logic [PD_BUS_BYTES-1:0]   wr_valid;
    logic [PD_BUS_WIDTH-1:0]   wr_data;
    logic                      flush;
    logic                      rd_ready;
    logic                      rd_valid;
    logic [PD_BUS_WIDTH-1:0]   rd_data;
    logic [6:0]                rd_count;

    modport master (
        output wr_en, wr_valid, wr_data, flush, rd_ready,
        input  rd_valid, rd_data, rd_count
    );

    modport slave (
        input  wr_en, wr_valid, wr_data, flush, rd_ready,
        output rd_valid, rd_data, rd_count
    );

endinterface

// File: rtl/pd_rx_byte_buffer_ring.sv
// Byte ring memory: multi-byte write at wr_ptr, 64-byte rotating read at rd_ptr, modulo depth.
module pd_byte_ring #(
    parameter  int DEPTH_BYTES = 256,
    localparam int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  wr_ptr,
    input  logic [6:0]     wr_cnt,
    input  logic [511:0]   wr_data,
    input  logic [AW-1:0]  rd_ptr,
    output logic [511:0]   rd_data
);

    logic [7:0]    mem_r [DEPTH_BYTES];
    logic [AW-1:0] off_s [DEPTH_BYTES];

    // Distance of each slot from the write pointer; selects which input byte lands there.
    always_comb begin
        for (int k = 0; k < DEPTH_BYTES; k++) begin
            off_s[k] = AW'(k) - wr_ptr;
        end
    end

    // Slots whose distance is below wr_cnt take their byte this cycle.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH_BYTES; k++) begin
            if (we && ({1'b0, off_s[k]} < {{(AW-6){1'b0}}, wr_cnt})) begin
                mem_r[k] <= wr_data[{off_s[k][5:0], 3'b000} +: 8];
            end
        end
    end

    // Rotating read window starting at rd_ptr.
    always_comb begin
        rd_data = '0;
        for (int j = 0; j < 64; j++) begin
            rd_data[8*j +: 8] = mem_r[rd_ptr + AW'(j)];
        end
    end

endmodule

// File: rtl/pd_rx_byte_buffer.sv
// Elastic byte buffer repacking variable-width PHY beats into 64-byte DLL words.
// Optional PD_RX_MASK_CHECK_EN adds a sticky mask_err and drops non-contiguous masks.
module pd_rx_byte_buffer
    import pd_rx_byte_buffer_pkg::*;
#(
    parameter  int DEPTH_BYTES = 256,
    parameter  int OUT_BYTES   = 64,
    parameter  int AF_LEVEL    = 192,
    localparam int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 linkup,
    pd_rx_byte_buffer_if.slave   bus,
    output logic [AW:0]          occupancy,
    output logic                 almost_full,
    output logic                 overflow
`ifdef PD_RX_MASK_CHECK_EN
    ,
    output logic                 mask_err
`endif
);

    logic [AW:0]   occupancy_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic          flush_pending_r;
    logic          almost_full_r;
    logic          overflow_r;

    logic [6:0]    wr_cnt_s;
    logic [AW:0]   free_s;
    logic          mask_ok_s;
    logic          fits_s;
    logic          wr_acc_s;
    logic          ovf_set_s;
    logic          rd_valid_s;
    logic [6:0]    rd_count_s;
    logic          rd_xfer_s;
    logic [AW:0]   occ_next_s;
    logic          fp_next_s;
    logic [511:0]  ring_rd_s;
    logic [511:0]  rd_data_s;

`ifdef PD_RX_MASK_CHECK_EN
    logic          mask_err_r;
    assign mask_ok_s = is_contiguous_mask(bus.wr_valid);
`else
    assign mask_ok_s = 1'b1;
`endif

    assign wr_cnt_s = popcount64(bus.wr_valid);
    assign free_s   = (AW+1)'(DEPTH_BYTES) - occupancy_r;
    assign fits_s   = ({{(AW-6){1'b0}}, wr_cnt_s} <= free_s);

    // Accept/drop decision, read presentation and next occupancy; space freed by a same-cycle read is not counted.
    always_comb begin
        wr_acc_s  = bus.wr_en & mask_ok_s & fits_s & (wr_cnt_s != 7'd0);
        ovf_set_s = bus.wr_en & mask_ok_s & ~fits_s;
        rd_valid_s = (occupancy_r >= (AW+1)'(OUT_BYTES)) |
                     (flush_pending_r & (occupancy_r != '0));
        if (!rd_valid_s) begin
            rd_count_s = 7'd0;
        end else if (occupancy_r >= (AW+1)'(OUT_BYTES)) begin
            rd_count_s = 7'(OUT_BYTES);
        end else begin
            rd_count_s = occupancy_r[6:0];
        end
        rd_xfer_s  = rd_valid_s & bus.rd_ready;
        occ_next_s = occupancy_r
                   + (wr_acc_s  ? {{(AW-6){1'b0}}, wr_cnt_s}   : '0)
                   - (rd_xfer_s ? {{(AW-6){1'b0}}, rd_count_s} : '0);
        fp_next_s  = (flush_pending_r | bus.flush) & (occ_next_s != '0);
    end

    pd_byte_ring #(.DEPTH_BYTES(DEPTH_BYTES)) u_ring (
        .clk     (clk),
        .we      (wr_acc_s & linkup & ~reset),
        .wr_ptr  (wr_ptr_r),
        .wr_cnt  (wr_cnt_s),
        .wr_data (bus.wr_data),
        .rd_ptr  (rd_ptr_r),
        .rd_data (ring_rd_s)
    );

    // Bytes beyond rd_count are forced to zero so the consumer never sees stale data.
    always_comb begin
        rd_data_s = '0;
        for (int j = 0; j < 64; j++) begin
            if (7'(j) < rd_count_s) begin
                rd_data_s[8*j +: 8] = ring_rd_s[8*j +: 8];
            end else begin
                rd_data_s[8*j +: 8] = 8'd0;
            end
        end
    end

    // Pointer, occupancy and flag state; link loss clears everything except the sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy_r     <= '0;
            wr_ptr_r        <= '0;
            rd_ptr_r        <= '0;
            flush_pending_r <= 1'b0;
            almost_full_r   <= 1'b0;
            overflow_r      <= 1'b0;
`ifdef PD_RX_MASK_CHECK_EN
            mask_err_r      <= 1'b0;
`endif
        end else if (!linkup) begin
            occupancy_r     <= '0;
            wr_ptr_r        <= '0;
            rd_ptr_r        <= '0;
            flush_pending_r <= 1'b0;
            almost_full_r   <= 1'b0;
        end else begin
            occupancy_r     <= occ_next_s;
            wr_ptr_r        <= wr_acc_s  ? wr_ptr_r + AW'(wr_cnt_s)   : wr_ptr_r;
            rd_ptr_r        <= rd_xfer_s ? rd_ptr_r + AW'(rd_count_s) : rd_ptr_r;
            flush_pending_r <= fp_next_s;
            almost_full_r   <= (occ_next_s >= (AW+1)'(AF_LEVEL));
            overflow_r      <= overflow_r | ovf_set_s;
`ifdef PD_RX_MASK_CHECK_EN
            mask_err_r      <= mask_err_r | (bus.wr_en & ~mask_ok_s);
`endif
        end
    end

    assign bus.rd_valid = rd_valid_s;
    assign bus.rd_count = rd_count_s;
    assign bus.rd_data  = rd_data_s;
    assign occupancy    = occupancy_r;
    assign almost_full  = almost_full_r;
    assign overflow     = overflow_r;
`ifdef PD_RX_MASK_CHECK_EN
    assign mask_err     = mask_err_r;
`endif

endmodule
